// File: rtl/prog_mem.sv
// prog_mem: parametrised program memory for the fetch stage.
// The debug unit streams a program in through a valid/ready load channel
// with an auto-incrementing write pointer. The IF stage then reads it with
// registered, single-cycle fetches. The block tracks the loaded length, so a
// fetch past the end, a misaligned fetch or one with stray upper address bits
// returns NOP_WORD and raises addr_err instead of returning stale contents.
module prog_mem #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 6,
   parameter int                BYTE_ADDR = 1,
   parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
   input  logic              clk,
   input  logic              rst,
   // fetch port
   input  logic              fetch_en,
   input  logic [31:0]       pc,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              addr_err,
   // load channel
   input  logic              load_start,
   input  logic              load_valid,
   input  logic              load_last,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              load_done,
   output logic [ADDR_W:0]   prog_len,
   output logic              running
);

   localparam int DEPTH = 2 ** ADDR_W;
   // Bit position of the word index inside pc, and the first bit above it.
   localparam int IDX_LSB = (BYTE_ADDR != 0) ? 2 : 0;
   localparam int IDX_TOP = IDX_LSB + ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   wr_ptr_q;
   logic [ADDR_W:0]     prog_len_q;
   logic [DATA_W-1:0]   instr_q;
   logic                instr_valid_q;
   logic                addr_err_q;
   logic                load_ready_q;
   logic                load_done_q;
   logic                running_q;

   logic [DATA_W-1:0]   mem [DEPTH];

   // Fetch address decode
   logic [ADDR_W-1:0]   fidx;
   logic                hi_nz;
   logic                misal;
   logic                beyond;
   logic                fetch_err;
   logic [DATA_W-1:0]   rd_word;

   assign fidx   = pc[IDX_LSB +: ADDR_W];
   // Any pc bit above the index field selects a word outside the array.
   assign hi_nz  = |(pc >> IDX_TOP);
   assign beyond = ({1'b0, fidx} >= prog_len_q);

   generate
      if (BYTE_ADDR != 0) begin : g_byte
         assign misal = |pc[1:0];
      end else begin : g_word
         assign misal = 1'b0;
      end
   endgenerate

   assign fetch_err = misal | hi_nz | beyond;
   assign rd_word   = mem[fidx];

   // Load handshake. load_start wins over a simultaneous word, which is dropped.
   logic xfer;
   logic wr_full;
   logic [ADDR_W:0] len_d;

   assign xfer    = (state_q == S_LOAD) & load_valid & ~load_start;
   assign wr_full = (wr_ptr_q == ADDR_W'(DEPTH - 1));
   assign len_d   = {1'b0, wr_ptr_q} + (ADDR_W + 1)'(1);

   // Program storage: not reset, prog_len alone decides which words are live.
   always_ff @(posedge clk) begin
      if (xfer) mem[wr_ptr_q] <= load_data;
   end

   // Control FSM with registered outputs: load sequencing and fetch results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         prog_len_q    <= '0;
         instr_q       <= NOP_WORD;
         instr_valid_q <= 1'b0;
         addr_err_q    <= 1'b0;
         load_ready_q  <= 1'b0;
         load_done_q   <= 1'b0;
         running_q     <= 1'b0;
      end else begin
         // Pulses default low. instr holds unless a fetch completes.
         load_done_q   <= 1'b0;
         instr_valid_q <= 1'b0;
         addr_err_q    <= 1'b0;
         if (load_start) begin
            // Fresh load from any state. Any fetch this cycle is dropped.
            state_q      <= S_LOAD;
            wr_ptr_q     <= '0;
            prog_len_q   <= '0;
            load_ready_q <= 1'b1;
            running_q    <= 1'b0;
         end else begin
            case (state_q)
               S_LOAD: begin
                  if (load_valid) begin
                     wr_ptr_q   <= wr_ptr_q + ADDR_W'(1);
                     prog_len_q <= len_d;
                     // Last word, or the array just filled up: start serving.
                     if (load_last || wr_full) begin
                        state_q      <= S_RUN;
                        load_ready_q <= 1'b0;
                        running_q    <= 1'b1;
                        load_done_q  <= 1'b1;
                     end
                  end
               end
               S_RUN: begin
                  if (fetch_en) begin
                     instr_valid_q <= 1'b1;
                     if (fetch_err) begin
                        instr_q    <= NOP_WORD;
                        addr_err_q <= 1'b1;
                     end else begin
                        instr_q    <= rd_word;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign addr_err    = addr_err_q;
   assign load_ready  = load_ready_q;
   assign load_done   = load_done_q;
   assign prog_len    = prog_len_q;
   assign running     = running_q;

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem (ADDR_W = 3, byte-addressed, non-zero NOP).
module tb_prog_mem;

   localparam int          AW    = 3;
   localparam int          DEPTH = 8;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst;
   logic          fetch_en;
   logic [31:0]   pc;
   logic [31:0]   instr;
   logic          instr_valid;
   logic          addr_err;
   logic          load_start;
   logic          load_valid;
   logic          load_last;
   logic [31:0]   load_data;
   logic          load_ready;
   logic          load_done;
   logic [AW:0]   prog_len;
   logic          running;

   prog_mem #(
      .DATA_W(32), .ADDR_W(AW), .BYTE_ADDR(1), .NOP_WORD(NOP)
   ) dut (
      .clk(clk), .rst(rst),
      .fetch_en(fetch_en), .pc(pc),
      .instr(instr), .instr_valid(instr_valid), .addr_err(addr_err),
      .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
      .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
      .prog_len(prog_len), .running(running)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        fen;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        vld;
      logic        err;
   } fvec_t;

   fvec_t tbl[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      fetch_en = 1'b0; pc = '0; load_start = 1'b0; load_valid = 1'b0;
      load_last = 1'b0; load_data = '0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".instr"}, instr, NOP);
      chk({tag, ".instr_valid"}, 32'(instr_valid), 0);
      chk({tag, ".addr_err"}, 32'(addr_err), 0);
      chk({tag, ".load_done"}, 32'(load_done), 0);
      chk({tag, ".load_ready"}, 32'(load_ready), 0);
      chk({tag, ".prog_len"}, 32'(prog_len), 0);
      chk({tag, ".running"}, 32'(running), 0);
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ee, input string tag);
      quiet(); fetch_en = 1'b1; pc = a;
      step();
      chk({tag, ".valid"}, 32'(instr_valid), 1);
      chk({tag, ".instr"}, instr, ei);
      chk({tag, ".err"}, 32'(addr_err), 32'(ee));
   endtask

   // Reference model state: the loaded program as a queue, plus a coarse mode.
   logic [31:0] mq[$];
   int          mmode;   // 0 idle, 1 loading, 2 serving
   logic [31:0] m_instr;

   initial begin
      quiet();
      rst = 1'b1;
      #12;
      chk_reset_vals("reset");
      rst = 1'b0;
      step();

      // ---- load four words ----
      load_start = 1'b1;
      step();
      chk("start.load_ready", 32'(load_ready), 1);
      chk("start.running", 32'(running), 0);
      for (int k = 0; k < 4; k++) begin
         quiet(); load_valid = 1'b1; load_data = 32'h11 * (k + 1); load_last = (k == 3);
         step();
         chk("ld4.prog_len", 32'(prog_len), 32'(k + 1));
         chk("ld4.load_done", 32'(load_done), (k == 3) ? 1 : 0);
      end
      chk("ld4.running", 32'(running), 1);
      chk("ld4.load_ready", 32'(load_ready), 0);
      quiet();
      step();
      chk("ld4.done_once", 32'(load_done), 0);

      // ---- table-driven fetches ----
      tbl[0]  = '{1'b1, 32'd0,  32'h11, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 32'd4,  32'h22, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 32'd8,  32'h33, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 32'd12, 32'h44, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 32'd16, NOP,    1'b1, 1'b1};  // i = 4 >= prog_len
      tbl[5]  = '{1'b1, 32'd6,  NOP,    1'b1, 1'b1};  // misaligned
      tbl[6]  = '{1'b0, 32'd0,  NOP,    1'b0, 1'b0};  // idle cycle holds instr
      tbl[7]  = '{1'b1, 32'd4,  32'h22, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 32'd8,  32'h22, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 32'd32, NOP,    1'b1, 1'b1};  // bits above index field
      tbl[10] = '{1'b1, 32'd1,  NOP,    1'b1, 1'b1};
      for (int t = 0; t < 11; t++) begin
         quiet(); fetch_en = tbl[t].fen; pc = tbl[t].pc;
         step();
         chk($sformatf("tbl%0d.instr", t), instr, tbl[t].ins);
         chk($sformatf("tbl%0d.valid", t), 32'(instr_valid), 32'(tbl[t].vld));
         chk($sformatf("tbl%0d.err", t), 32'(addr_err), 32'(tbl[t].err));
      end

      // ---- reload during RUN, fetch in the same cycle is dropped ----
      quiet(); load_start = 1'b1; fetch_en = 1'b1; pc = 0;
      step();
      chk("reload.drop_valid", 32'(instr_valid), 0);
      chk("reload.prog_len", 32'(prog_len), 0);
      quiet(); load_valid = 1'b1; load_data = 32'hA0;
      step();
      quiet(); load_valid = 1'b1; load_data = 32'hA1; load_last = 1'b1;
      step();
      chk("reload.prog_len2", 32'(prog_len), 2);
      fetch(32'd8, NOP, 1'b1, "reload.old3rd");
      fetch(32'd4, 32'hA1, 1'b0, "reload.w1");

      // ---- fill the array without load_last ----
      quiet(); load_start = 1'b1;
      step();
      for (int k = 0; k < 9; k++) begin
         quiet(); load_valid = 1'b1; load_data = 32'h100 + k;
         chk($sformatf("full%0d.ready", k), 32'(load_ready), (k < 8) ? 1 : 0);
         step();
         if (k == 7) begin
            chk("full.done", 32'(load_done), 1);
            chk("full.running", 32'(running), 1);
         end
      end
      chk("full.prog_len", 32'(prog_len), 8);
      chk("full.done_gone", 32'(load_done), 0);
      fetch(32'd28, 32'h107, 1'b0, "full.last");
      fetch(32'd0, 32'h100, 1'b0, "full.first");

      // ---- load_start beats a simultaneous transfer ----
      quiet(); load_start = 1'b1;
      step();
      quiet(); load_valid = 1'b1; load_data = 32'h55;
      step();
      chk("prio.len1", 32'(prog_len), 1);
      quiet(); load_start = 1'b1; load_valid = 1'b1; load_data = 32'h66;
      step();
      chk("prio.len0", 32'(prog_len), 0);
      chk("prio.ready", 32'(load_ready), 1);
      quiet(); load_valid = 1'b1; load_data = 32'h77; load_last = 1'b1;
      step();
      chk("prio.len_after", 32'(prog_len), 1);
      fetch(32'd0, 32'h77, 1'b0, "prio.w0");
      fetch(32'd4, NOP, 1'b1, "prio.w1");

      // ---- asynchronous reset mid-load ----
      quiet(); load_start = 1'b1;
      step();
      for (int k = 0; k < 2; k++) begin
         quiet(); load_valid = 1'b1; load_data = 32'hC0 + k;
         step();
      end
      #2 rst = 1'b1;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk);
      rst = 1'b0;
      quiet(); fetch_en = 1'b1; pc = 0;
      step();
      chk("idle_fetch.valid", 32'(instr_valid), 0);
      chk("idle_fetch.running", 32'(running), 0);
      chk("idle_fetch.ready", 32'(load_ready), 0);

      // ---- randomized traffic against the reference model ----
      quiet(); rst = 1'b1; #1; rst = 1'b0;
      mq.delete(); mmode = 0; m_instr = NOP;
      for (int c = 0; c < 600; c++) begin
         logic        e_vld, e_err, e_done;
         int          sel;
         quiet();
         load_start = ($urandom_range(0, 39) == 0) || (mmode == 0 && $urandom_range(0, 3) == 0);
         load_valid = ($urandom_range(0, 9) < 7);
         load_last  = ($urandom_range(0, 5) == 0);
         load_data  = $urandom;
         fetch_en   = ($urandom_range(0, 9) < 8);
         sel = $urandom_range(0, 3);
         case (sel)
            0: pc = 4 * $urandom_range(0, DEPTH - 1);
            1: pc = $urandom_range(0, 63);
            2: pc = 4 * $urandom_range(DEPTH, 4 * DEPTH);
            default: pc = $urandom;
         endcase
         e_vld = 0; e_err = 0; e_done = 0;
         if (load_start) begin
            mmode = 1; mq.delete();
         end else if (mmode == 1) begin
            if (load_valid) begin
               mq.push_back(load_data);
               if (load_last || mq.size() == DEPTH) begin
                  mmode = 2; e_done = 1;
               end
            end
         end else if (mmode == 2 && fetch_en) begin
            e_vld = 1;
            if (pc % 4 != 0 || pc / 4 >= mq.size()) begin
               e_err = 1; m_instr = NOP;
            end else begin
               m_instr = mq[pc / 4];
            end
         end
         step();
         chk("rnd.valid", 32'(instr_valid), 32'(e_vld));
         chk("rnd.err", 32'(addr_err), 32'(e_err));
         chk("rnd.done", 32'(load_done), 32'(e_done));
         chk("rnd.instr", instr, m_instr);
         chk("rnd.prog_len", 32'(prog_len), mq.size());
         chk("rnd.ready", 32'(load_ready), (mmode == 1) ? 1 : 0);
         chk("rnd.running", 32'(running), (mmode == 2) ? 1 : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
